// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg - definitions shared by the torus seed loader and the dumper.
//
// Contents:
//   CHAR_ALIVE / CHAR_DEAD / CHAR_CR / CHAR_LF - UART character protocol
//   sdumper_state_t                            - dumper FSM state encoding
//   cnt_width()                                - counter width, minimum 1 bit
// ---------------------------------------------------------------------------
package life_pkg;

    localparam logic [7:0] CHAR_ALIVE = 8'h2A;  // '*'
    localparam logic [7:0] CHAR_DEAD  = 8'h2D;  // '-'
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        SD_IDLE,
        SD_CELL,
        SD_GUARD,
        SD_CR,
        SD_LF,
        SD_DONE
    } sdumper_state_t;

    // Width of a counter spanning 0..n-1; a single-entry range still needs 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdumper.sv
// ---------------------------------------------------------------------------
// sdumper - serialises the current torus generation over UART.
//
// Each cell is read from torus_last and recirculated into seed with a
// seed_ena pulse, so after one full revolution the torus is unchanged.
// Alive cells go out as '*', dead cells as '-', optionally CR LF per row.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   dump request pulse, ignored while busy
//   torus_last in   last cell of the torus shift chain
//   tx_busy    in   UART transmitter busy (rises the cycle after tx_send)
//   seed       out  bit shifted back into the torus
//   seed_ena   out  torus shift enable, one pulse per cell
//   tx_byte    out  byte to transmit, held until the next send
//   tx_send    out  single-cycle transmit strobe
//   busy       out  dump in progress
//   done       out  single-cycle pulse after the last byte is handed over
// ---------------------------------------------------------------------------
module sdumper
    import life_pkg::*;
#(
    parameter int TORUS_WIDTH  = 32,
    parameter int TORUS_HEIGHT = 16,
    parameter bit EOL_ENA      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       torus_last,
    input  logic       tx_busy,
    output logic       seed,
    output logic       seed_ena,
    output logic [7:0] tx_byte,
    output logic       tx_send,
    output logic       busy,
    output logic       done
);

    localparam int COL_W = cnt_width(TORUS_WIDTH);
    localparam int ROW_W = cnt_width(TORUS_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TORUS_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TORUS_HEIGHT - 1);

    sdumper_state_t   state, state_d;
    sdumper_state_t   ret, ret_d;       // state to enter after GUARD
    logic [COL_W-1:0] col, col_d;
    logic [ROW_W-1:0] row, row_d;
    logic             seed_d, seed_ena_d, tx_send_d, busy_d, done_d;
    logic [7:0]       tx_byte_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SD_IDLE;
            ret      <= SD_IDLE;
            col      <= '0;
            row      <= '0;
            seed     <= 1'b0;
            seed_ena <= 1'b0;
            tx_byte  <= 8'h00;
            tx_send  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            ret      <= ret_d;
            col      <= col_d;
            row      <= row_d;
            seed     <= seed_d;
            seed_ena <= seed_ena_d;
            tx_byte  <= tx_byte_d;
            tx_send  <= tx_send_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        ret_d      = ret;
        col_d      = col;
        row_d      = row;
        seed_d     = seed;
        seed_ena_d = 1'b0;
        tx_byte_d  = tx_byte;
        tx_send_d  = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state)
            SD_IDLE: begin
                if (start) begin
                    col_d   = '0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SD_CELL;
                end
            end

            SD_CELL: begin
                if (!tx_busy) begin
                    tx_byte_d  = torus_last ? CHAR_ALIVE : CHAR_DEAD;
                    tx_send_d  = 1'b1;
                    seed_d     = torus_last;
                    seed_ena_d = 1'b1;
                    state_d    = SD_GUARD;
                    if (col != COL_LAST) begin
                        col_d = col + COL_W'(1);
                        ret_d = SD_CELL;
                    end else if (EOL_ENA) begin
                        col_d = '0;
                        ret_d = SD_CR;
                    end else if (row != ROW_LAST) begin
                        col_d = '0;
                        row_d = row + ROW_W'(1);
                        ret_d = SD_CELL;
                    end else begin
                        ret_d = SD_DONE;
                    end
                end
            end

            // The UART only raises tx_busy one cycle after tx_send, so its
            // value here is stale; this cycle also lets the torus shift
            // settle before torus_last is sampled again.
            SD_GUARD: begin
                state_d = ret;
            end

            SD_CR: begin
                if (!tx_busy) begin
                    tx_byte_d = CHAR_CR;
                    tx_send_d = 1'b1;
                    state_d   = SD_GUARD;
                    ret_d     = SD_LF;
                end
            end

            SD_LF: begin
                if (!tx_busy) begin
                    tx_byte_d = CHAR_LF;
                    tx_send_d = 1'b1;
                    state_d   = SD_GUARD;
                    if (row == ROW_LAST) begin
                        ret_d = SD_DONE;
                    end else begin
                        row_d = row + ROW_W'(1);
                        ret_d = SD_CELL;
                    end
                end
            end

            SD_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = SD_IDLE;
            end

            default: begin
                state_d = SD_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdumper.sv
// ---------------------------------------------------------------------------
// tb_sdumper - bench for sdumper.
//
// Three instances: A (4x2, CR LF), B (4x2, cells only), C (1x1, CR LF).
// Each has a torus shift-register model and A/B a UART busy model with a
// randomised busy length. Expected byte streams are built from the torus
// contents captured at start.
// ---------------------------------------------------------------------------
module tb_sdumper;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 4x2, EOL ----------------
    logic       start_a = 1'b0, tx_busy_a, hold_a = 1'b0;
    logic       seed_a, seed_ena_a, tx_send_a, busy_a, done_a;
    logic [7:0] tx_byte_a;
    logic [7:0] torus_a = 8'h00, load_val_a = 8'h00;
    logic       load_a = 1'b0, clr_a = 1'b0;
    int         blen_a = 10, bcnt_a = 0;
    bq_t        q_a;
    int         sc_a[$];
    int         se_a = 0, dn_a = 0, dcyc_a = 0, viol_a = 0;
    logic       busy_at_done_a = 1'b0, prv_send_a = 1'b0, prv_se_a = 1'b0;

    sdumper #(.TORUS_WIDTH(4), .TORUS_HEIGHT(2), .EOL_ENA(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .torus_last(torus_a[0]),
        .tx_busy(tx_busy_a), .seed(seed_a), .seed_ena(seed_ena_a),
        .tx_byte(tx_byte_a), .tx_send(tx_send_a), .busy(busy_a), .done(done_a)
    );

    always @(posedge clk) begin
        if (load_a) torus_a <= load_val_a;
        else if (seed_ena_a) torus_a <= {seed_a, torus_a[7:1]};
        if (reset) bcnt_a <= 0;
        else if (tx_send_a) bcnt_a <= blen_a;
        else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
    end
    assign tx_busy_a = (bcnt_a != 0) || hold_a;

    always @(negedge clk) begin
        if (clr_a) begin
            q_a.delete(); sc_a.delete();
            se_a = 0; dn_a = 0; dcyc_a = 0;
        end else begin
            if (tx_send_a) begin q_a.push_back(tx_byte_a); sc_a.push_back(cyc); end
            if (seed_ena_a) se_a++;
            if (done_a) begin dn_a++; dcyc_a = cyc; busy_at_done_a = busy_a; end
            if ((tx_send_a && prv_send_a) || (seed_ena_a && prv_se_a)) viol_a++;
        end
        prv_send_a = tx_send_a;
        prv_se_a   = seed_ena_a;
    end

    // ---------------- instance B: 4x2, no EOL ----------------
    logic       start_b = 1'b0, tx_busy_b;
    logic       seed_b, seed_ena_b, tx_send_b, busy_b, done_b;
    logic [7:0] tx_byte_b;
    logic [7:0] torus_b = 8'h00, load_val_b = 8'h00;
    logic       load_b = 1'b0, clr_b = 1'b0;
    int         blen_b = 10, bcnt_b = 0;
    bq_t        q_b;
    int         sc_b[$];
    int         se_b = 0, dn_b = 0, dcyc_b = 0, viol_b = 0;
    logic       prv_send_b = 1'b0, prv_se_b = 1'b0;

    sdumper #(.TORUS_WIDTH(4), .TORUS_HEIGHT(2), .EOL_ENA(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .torus_last(torus_b[0]),
        .tx_busy(tx_busy_b), .seed(seed_b), .seed_ena(seed_ena_b),
        .tx_byte(tx_byte_b), .tx_send(tx_send_b), .busy(busy_b), .done(done_b)
    );

    always @(posedge clk) begin
        if (load_b) torus_b <= load_val_b;
        else if (seed_ena_b) torus_b <= {seed_b, torus_b[7:1]};
        if (reset) bcnt_b <= 0;
        else if (tx_send_b) bcnt_b <= blen_b;
        else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    end
    assign tx_busy_b = (bcnt_b != 0);

    always @(negedge clk) begin
        if (clr_b) begin
            q_b.delete(); sc_b.delete();
            se_b = 0; dn_b = 0; dcyc_b = 0;
        end else begin
            if (tx_send_b) begin q_b.push_back(tx_byte_b); sc_b.push_back(cyc); end
            if (seed_ena_b) se_b++;
            if (done_b) begin dn_b++; dcyc_b = cyc; end
            if ((tx_send_b && prv_send_b) || (seed_ena_b && prv_se_b)) viol_b++;
        end
        prv_send_b = tx_send_b;
        prv_se_b   = seed_ena_b;
    end

    // ---------------- instance C: 1x1, EOL, tx_busy tied low ----------------
    logic       start_c = 1'b0;
    logic       seed_c, seed_ena_c, tx_send_c, busy_c, done_c;
    logic [7:0] tx_byte_c;
    logic       torus_c = 1'b0, load_val_c = 1'b0, load_c = 1'b0, clr_c = 1'b0;
    bq_t        q_c;
    int         sc_c[$];
    int         dn_c = 0, dcyc_c = 0;

    sdumper #(.TORUS_WIDTH(1), .TORUS_HEIGHT(1), .EOL_ENA(1'b1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .torus_last(torus_c),
        .tx_busy(1'b0), .seed(seed_c), .seed_ena(seed_ena_c),
        .tx_byte(tx_byte_c), .tx_send(tx_send_c), .busy(busy_c), .done(done_c)
    );

    always @(posedge clk) begin
        if (load_c) torus_c <= load_val_c;
        else if (seed_ena_c) torus_c <= seed_c;
    end

    always @(negedge clk) begin
        if (clr_c) begin
            q_c.delete(); sc_c.delete();
            dn_c = 0; dcyc_c = 0;
        end else begin
            if (tx_send_c) begin q_c.push_back(tx_byte_c); sc_c.push_back(cyc); end
            if (done_c) begin dn_c++; dcyc_c = cyc; end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: cells in torus_last order, row by row, optional CR LF.
    function automatic bq_t exp_stream(input logic [7:0] t, input int w, input int h, input bit eol);
        bq_t q;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) q.push_back(t[r*w + c] ? 8'h2A : 8'h2D);
            if (eol) begin q.push_back(8'h0D); q.push_back(8'h0A); end
        end
        return q;
    endfunction

    task automatic cmp_stream(input string tag, input bq_t got, input bq_t exp);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
    endtask

    task automatic load_torus_a(input logic [7:0] v);
        load_val_a = v; load_a = 1'b1; tick(1); load_a = 1'b0;
    endtask

    task automatic clear_a();
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1; tick(1); start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int lim);
        for (int n = 0; n < lim && dn_a == 0; n++) tick(1);
        chk({tag, "_done_seen"}, (dn_a != 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic finish_checks_a(input string tag, input logic [7:0] snap);
        int last;
        last = (sc_a.size() > 0) ? sc_a[sc_a.size()-1] : -100;
        cmp_stream(tag, q_a, exp_stream(snap, 4, 2, 1'b1));
        chk({tag, "_seed_ena"}, se_a, 32'd8);
        chk({tag, "_torus"}, {24'h0, torus_a}, {24'h0, snap});
        chk({tag, "_busy_at_done"}, {31'h0, busy_at_done_a}, 32'd0);
        chk({tag, "_done_lat"}, dcyc_a - last, 32'd2);
        tick(60);
        chk({tag, "_done_cnt"}, dn_a, 32'd1);
        chk({tag, "_len_after"}, q_a.size(), 32'd12);
    endtask

    task automatic dump_a(input string tag, input logic [7:0] t, input bit poke);
        load_torus_a(t);
        blen_a = int'($urandom_range(1, 12));
        clear_a();
        pulse_start_a();
        if (poke) begin
            tick(20);
            chk({tag, "_busy_mid"}, {31'h0, busy_a}, 32'd1);
            pulse_start_a();
        end
        wait_done_a(tag, 2000);
        finish_checks_a(tag, t);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] snap;
        logic [7:0] tb_v;
        int base_s, base_e, s;

        reset = 1'b1;
        tick(3);
        chk("rst_seed", {31'h0, seed_a}, 32'd0);
        chk("rst_seed_ena", {31'h0, seed_ena_a}, 32'd0);
        chk("rst_tx_byte", {24'h0, tx_byte_a}, 32'd0);
        chk("rst_tx_send", {31'h0, tx_send_a}, 32'd0);
        chk("rst_busy", {31'h0, busy_a}, 32'd0);
        chk("rst_done", {31'h0, done_a}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Directed pattern: torus_last order 1010_0011, with a stray start mid-dump.
        blen_a = 10;
        dump_a("a_dir", 8'b1100_0101, 1'b1);
        cmp_stream("a_lit", exp_stream(8'b1100_0101, 4, 2, 1'b1),
                   '{8'h2A, 8'h2D, 8'h2A, 8'h2D, 8'h0D, 8'h0A, 8'h2D, 8'h2D, 8'h2A, 8'h2A, 8'h0D, 8'h0A});

        // Random patterns and UART busy lengths.
        for (int k = 0; k < 4; k++) dump_a($sformatf("a_rnd%0d", k), 8'($urandom), 1'b0);

        // tx_busy held high for 500 cycles mid-row.
        snap = 8'($urandom);
        load_torus_a(snap);
        blen_a = int'($urandom_range(1, 12));
        clear_a();
        pulse_start_a();
        for (int n = 0; n < 500 && q_a.size() < 3; n++) tick(1);
        hold_a = 1'b1;
        base_s = q_a.size();
        base_e = se_a;
        tick(500);
        chk("stall_send", q_a.size(), base_s);
        chk("stall_seed_ena", se_a, base_e);
        chk("stall_busy", {31'h0, busy_a}, 32'd1);
        hold_a = 1'b0;
        wait_done_a("stall", 2000);
        finish_checks_a("stall", snap);

        // Reset after 3 cells, then a full dump from the partially rotated torus.
        load_torus_a(8'($urandom));
        clear_a();
        pulse_start_a();
        for (int n = 0; n < 500 && se_a < 3; n++) tick(1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_seed", {31'h0, seed_a}, 32'd0);
        chk("mid_rst_seed_ena", {31'h0, seed_ena_a}, 32'd0);
        chk("mid_rst_tx_byte", {24'h0, tx_byte_a}, 32'd0);
        chk("mid_rst_tx_send", {31'h0, tx_send_a}, 32'd0);
        chk("mid_rst_busy", {31'h0, busy_a}, 32'd0);
        chk("mid_rst_done", {31'h0, done_a}, 32'd0);
        reset = 1'b0;
        tick(2);
        snap = torus_a;
        clear_a();
        pulse_start_a();
        wait_done_a("post_rst", 2000);
        finish_checks_a("post_rst", snap);

        // Instance B: cells only.
        for (int k = 0; k < 3; k++) begin
            tb_v = 8'($urandom);
            load_val_b = tb_v; load_b = 1'b1; tick(1); load_b = 1'b0;
            blen_b = int'($urandom_range(1, 12));
            clr_b = 1'b1; tick(1); clr_b = 1'b0;
            start_b = 1'b1; tick(1); start_b = 1'b0;
            for (int n = 0; n < 2000 && dn_b == 0; n++) tick(1);
            chk("b_done_seen", (dn_b != 0) ? 32'd1 : 32'd0, 32'd1);
            cmp_stream($sformatf("b%0d", k), q_b, exp_stream(tb_v, 4, 2, 1'b0));
            chk("b_seed_ena", se_b, 32'd8);
            chk("b_torus", {24'h0, torus_b}, {24'h0, tb_v});
            chk("b_done_lat", dcyc_b - ((sc_b.size() > 0) ? sc_b[sc_b.size()-1] : -100), 32'd2);
            chk("b_busy_after", {31'h0, busy_b}, 32'd0);
        end

        // start coincident with reset on B: reset wins.
        clr_b = 1'b1; tick(1); clr_b = 1'b0;
        reset = 1'b1; start_b = 1'b1;
        tick(1);
        reset = 1'b0; start_b = 1'b0;
        chk("rst_start_busy", {31'h0, busy_b}, 32'd0);
        tick(20);
        chk("rst_start_sends", q_b.size(), 32'd0);

        // Instance C: 1x1 latency.
        load_val_c = 1'($urandom); load_c = 1'b1; tick(1); load_c = 1'b0;
        clr_c = 1'b1; tick(1); clr_c = 1'b0;
        s = cyc;
        start_c = 1'b1; tick(1); start_c = 1'b0;
        for (int n = 0; n < 100 && dn_c == 0; n++) tick(1);
        chk("c_done_seen", (dn_c != 0) ? 32'd1 : 32'd0, 32'd1);
        chk("c_send0_cyc", (sc_c.size() > 0) ? sc_c[0] - s : -1, 32'd2);
        chk("c_send1_cyc", (sc_c.size() > 1) ? sc_c[1] - s : -1, 32'd4);
        chk("c_send2_cyc", (sc_c.size() > 2) ? sc_c[2] - s : -1, 32'd6);
        chk("c_done_cyc", dcyc_c - s, 32'd8);
        cmp_stream("c", q_c, exp_stream({7'h0, load_val_c}, 1, 1, 1'b1));
        chk("c_torus", {31'h0, torus_c}, {31'h0, load_val_c});

        chk("a_back_to_back", viol_a, 32'd0);
        chk("b_back_to_back", viol_b, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
